dso_trig_capture: RTL

Trigger-and-capture stage directly downstream of the DDS waveform generator in the DSO path. It consumes the 8-bit sample stream, detects a level/edge trigger, and stores a window of samples with a programmable pre-trigger depth in an internal ring buffer. After capture completes, display/DDR logic reads the window back in chronological order.

---
 rtl/dso_trig_capture.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dso_trig_capture.sv
// Level/edge triggered capture of an 8-bit sample stream into a ring buffer with pre-trigger depth.
// Defining DSO_TRIG_TIMEOUT_EN adds an auto-trigger after TIMEOUT_CYC clocks spent waiting.
module dso_trig_capture #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned PRE_TRIG    = 256,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          start,
  input  logic [7:0]    trig_level,
  input  logic          trig_edge,
  input  logic [7:0]    data_in,
  input  logic          data_in_vld,
  output logic          busy,
  output logic          done,
  output logic          trig_forced,
  output logic [AW-1:0] start_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int unsigned POST_LEN = DEPTH - PRE_TRIG - 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StPost = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pre_cnt;
  logic [AW-1:0] post_cnt;
  logic [7:0]    prev;
  logic          prev_vld;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_phys;

  logic accept, capturing, wr_en, edge_hit, true_trig, forced_trig, trig;

  assign accept    = start && (state == StIdle || state == StDone);
  assign capturing = (state == StPre) || (state == StWait) || (state == StPost);
  assign wr_en     = capturing && data_in_vld;
  assign edge_hit  = trig_edge ? (prev >= trig_level && data_in < trig_level)
                               : (prev < trig_level && data_in >= trig_level);
  assign true_trig = (state == StWait) && wr_en && prev_vld && edge_hit;

`ifdef DSO_TRIG_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Saturates at TIMEOUT_CYC so the forced trigger waits for the next valid sample.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (state == StWait && to_cnt != TIMEOUT_CYC) begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  assign forced_trig = (state == StWait) && wr_en && (to_cnt == TIMEOUT_CYC);
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYC);
  assign forced_trig    = 1'b0;
`endif

  assign trig = true_trig || forced_trig;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= StIdle;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      prev        <= '0;
      prev_vld    <= 1'b0;
      start_addr  <= '0;
      trig_forced <= 1'b0;
    end else if (accept) begin
      state       <= (PRE_TRIG == 0) ? StWait : StPre;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      prev_vld    <= 1'b0;
      trig_forced <= 1'b0;
    end else if (wr_en) begin
      wr_ptr   <= wr_ptr + 1'b1;
      prev     <= data_in;
      prev_vld <= 1'b1;
      case (state)
        StPre: begin
          pre_cnt <= pre_cnt + 1'b1;
          if (pre_cnt == AW'(PRE_TRIG - 1)) state <= StWait;
        end
        StWait: begin
          if (trig) begin
            start_addr  <= wr_ptr - AW'(PRE_TRIG);
            trig_forced <= !true_trig;
            state       <= (POST_LEN == 0) ? StDone : StPost;
          end
        end
        StPost: begin
          post_cnt <= post_cnt + 1'b1;
          if (post_cnt == AW'(POST_LEN - 1)) state <= StDone;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

  assign rd_phys = start_addr + rd_addr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rd_data <= '0;
    else            rd_data <= mem[rd_phys];
  end

  assign busy = capturing;
  assign done = (state == StDone);

endmodule
